// File: rtl/boot_sequencer_pkg.sv
// boot_sequencer_pkg: copy FSM states plus default bus widths when the
// surrounding build has not already set ADDR_SIZE / WORD_SIZE.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
package boot_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, WRITE, DONE} state_t;
endpackage

// File: rtl/boot_settle_timer.sv
// boot_settle_timer: loadable down-counter whose zero flag marks the end of
// the ROM settle window.
module boot_settle_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   assign zero = cnt == '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: copies the ROM image into RAM word by word, then releases the CPU.
// Define BOOT_CHECKSUM_EN to add a running sum of every accepted write word.
module boot_sequencer
   import boot_sequencer_pkg::*;
#(
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 20,
   parameter int STEP       = 2,
   parameter int SETTLE_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  ram_ack,
   input  logic [`WORD_SIZE-1:0] data,
   output logic                  boot,
   output logic [`ADDR_SIZE-1:0] mem_addr,
   output logic                  ram_we,
   output logic                  busy,
   output logic                  done,
   output logic                  cpu_run
`ifdef BOOT_CHECKSUM_EN
   ,
   output logic [`WORD_SIZE-1:0] checksum
`endif
);
   localparam int SPAN = (END_ADDR - START_ADDR) & ((1 << `ADDR_SIZE) - 1);
   if (SPAN % STEP != 0) begin : g_bad_end
      $error("END_ADDR is not reachable from START_ADDR in STEP increments");
   end
   if (SETTLE_CYC < 1 || SETTLE_CYC > 7) begin : g_bad_settle
      $error("SETTLE_CYC must lie in 1..7");
   end
   state_t state, next;
   logic go, zero, last;
   assign go   = start && (state == IDLE || state == DONE);
   assign last = mem_addr == `ADDR_SIZE'(END_ADDR);
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE: next = go ? SETTLE : state;
         SETTLE:     next = zero ? WRITE : SETTLE;
         WRITE:      next = ram_ack ? (last ? DONE : SETTLE) : WRITE;
         default:    next = IDLE;
      endcase
   end
   // Loading SETTLE_CYC-1 makes the zero flag fire on the last settle cycle.
   boot_settle_timer #(.W(3)) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .load(next == SETTLE && state != SETTLE),
      .en(state == SETTLE),
      .load_val(3'(SETTLE_CYC - 1)),
      .zero(zero)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         mem_addr <= `ADDR_SIZE'(START_ADDR);
         boot     <= 1'b0;
         ram_we   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cpu_run  <= 1'b0;
      end else begin
         state    <= next;
         boot     <= next == SETTLE || next == WRITE;
         busy     <= next == SETTLE || next == WRITE;
         ram_we   <= next == WRITE;
         done     <= next == DONE;
         cpu_run  <= next == DONE;
         if (go) mem_addr <= `ADDR_SIZE'(START_ADDR);
         else if (state == WRITE && ram_ack && !last) mem_addr <= mem_addr + `ADDR_SIZE'(STEP);
      end
`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) checksum <= '0;
      else if (go) checksum <= '0;
      else if (ram_we && ram_ack) checksum <= checksum + data;
`else
   logic unused_data;
   assign unused_data = ^data;
`endif
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: table vectors on a single-word instance plus scripted and
// random copies on the default instance, checked against a transfer-level model.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
module tb_boot_sequencer;
   localparam logic [`WORD_SIZE-1:0] W0 = 16'h1234, W2 = 16'hABCD, W4 = 16'h9F01;
   logic clk = 0, rst_n = 0;
   logic start0 = 0, ack0 = 0, start1 = 0, ack1 = 0;
   logic [`WORD_SIZE-1:0] data = '0;
   logic boot0, we0, busy0, done0, run0, boot1, we1, busy1, done1, run1;
   logic [`ADDR_SIZE-1:0] addr0, addr1;
`ifdef BOOT_CHECKSUM_EN
   logic [`WORD_SIZE-1:0] cks0, cks1;
`endif
   int checks = 0, errors = 0;
   int cyc, wr, waits, bad, we4, ea;
   logic [`WORD_SIZE-1:0] sum;
   always #5 clk = ~clk;

   boot_sequencer u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .ram_ack(ack0), .data(data),
      .boot(boot0), .mem_addr(addr0), .ram_we(we0), .busy(busy0), .done(done0), .cpu_run(run0)
`ifdef BOOT_CHECKSUM_EN
      , .checksum(cks0)
`endif
   );
   boot_sequencer #(.START_ADDR(6), .END_ADDR(6)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .ram_ack(ack1), .data(data),
      .boot(boot1), .mem_addr(addr1), .ram_we(we1), .busy(busy1), .done(done1), .cpu_run(run1)
`ifdef BOOT_CHECKSUM_EN
      , .checksum(cks1)
`endif
   );

   function automatic logic [`WORD_SIZE-1:0] rom(input logic [`ADDR_SIZE-1:0] a);
      case (a)
         0: return W0;
         2: return W2;
         4: return W4;
         18: return 16'h8000;
         20: return 16'h0001;
         default: return '0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transfer-level model: each accepted write must hit the next word address,
   // and the copy takes (SETTLE_CYC+1) cycles per word plus every stalled WRITE cycle.
   task automatic run_copy(input int mode, input bit pulse);
      cyc = 0; wr = 0; waits = 0; bad = 0; we4 = 0; ea = 0; sum = '0;
      if (pulse) begin
         start0 = 1;
         step();
         start0 = 0;
      end else ea = 0;
      while (!done0 && cyc < 500) begin
         if (we0 && addr0 == 4) we4++;
         ack0 = mode == 0 ? 1'b1 : mode == 1 ? !(we0 && addr0 == 4 && we4 < 4) : ($urandom_range(0, 2) != 0);
         start0 = mode == 2 && $urandom_range(0, 7) == 0;
         data = rom(addr0);
         if (we0 && ack0) begin
            wr++;
            if (int'(addr0) != ea) bad++;
            ea += 2;
            sum += data;
         end
         if (we0 && !ack0) waits++;
         if (boot0 && run0) bad++;
         step();
         cyc++;
      end
      start0 = 0;
      ack0 = 0;
   endtask

   typedef struct {
      logic st;
      logic ack;
      logic [4:0] exp;
   } vec_t;
   vec_t vecs[10];

   initial begin
      // {boot, ram_we, busy, done, cpu_run}
      vecs = '{'{0, 0, 5'b00000}, '{1, 1, 5'b10100}, '{0, 1, 5'b11100}, '{1, 0, 5'b11100},
               '{0, 1, 5'b00011}, '{0, 1, 5'b00011}, '{1, 0, 5'b10100}, '{0, 0, 5'b11100},
               '{0, 0, 5'b11100}, '{0, 1, 5'b00011}};
      #3;
      check("reset_state", {boot0, we0, busy0, done0, run0, addr0}, {5'b0, 16'd0});
      #4 rst_n = 1;
      step();
      for (int i = 0; i < 10; i++) begin
         start1 = vecs[i].st;
         ack1 = vecs[i].ack;
         step();
         check($sformatf("vec%0d", i), {boot1, we1, busy1, done1, run1, addr1}, {vecs[i].exp, 16'd6});
      end
      start1 = 0; ack1 = 0;

      run_copy(0, 1);
      check("a_cycles", cyc, 22);
      check("a_writes", wr, 11);
      check("a_bad", bad, 0);
      check("a_final", {boot0, we0, busy0, done0, run0}, 5'b00011);
`ifdef BOOT_CHECKSUM_EN
      check("a_checksum", cks0, W0 + W2 + W4 + 16'h8001);
`endif
      start0 = 1;
      step();
      start0 = 0;
      check("restart", {boot0, busy0, done0, run0, addr0}, {4'b1100, 16'd0});
`ifdef BOOT_CHECKSUM_EN
      check("restart_cks", cks0, 0);
`endif
      run_copy(0, 0);
      check("restart_writes", wr, 11);
      check("restart_bad", bad, 0);

      run_copy(1, 1);
      check("b_we_at_4", we4, 4);
      check("b_writes", wr, 11);
      check("b_bad", bad, 0);
      check("b_cycles", cyc, 25);

      for (int r = 0; r < 3; r++) begin
         run_copy(2, 1);
         check($sformatf("rnd%0d_cycles", r), cyc, 22 + waits);
         check($sformatf("rnd%0d_writes", r), wr, 11);
         check($sformatf("rnd%0d_bad", r), bad, 0);
         check($sformatf("rnd%0d_done", r), {done0, run0, boot0}, 3'b110);
`ifdef BOOT_CHECKSUM_EN
         check($sformatf("rnd%0d_cks", r), cks0, sum);
`endif
      end

      start0 = 1;
      step();
      start0 = 0;
      ack0 = 1;
      cyc = 0;
      while (!(we0 && addr0 == 10) && cyc < 100) begin
         step();
         cyc++;
      end
      ack0 = 0;
      check("reach_a10", {we0, addr0}, {1'b1, 16'd10});
      #3 rst_n = 0;
      #1 check("async_rst", {boot0, we0, busy0, done0, run0, addr0}, {5'b0, 16'd0});
      #2 rst_n = 1;
      repeat (3) step();
      check("idle_after_rst", {boot0, we0, busy0, done0, run0}, 5'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
